// File: rtl/kbd_pkg.sv
// Shared scan-code constants, digit decode helper and receiver state type
// for the PS/2 keyboard front end.
package kbd_pkg;

  localparam logic [7:0] NO_KEY    = 8'hFF;
  localparam logic [7:0] BREAK     = 8'hF0;
  localparam logic [7:0] EXT       = 8'hE0;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_T     = 8'h2C;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  localparam logic [7:0] MAKE_0 = 8'h45;
  localparam logic [7:0] MAKE_1 = 8'h16;
  localparam logic [7:0] MAKE_2 = 8'h1E;
  localparam logic [7:0] MAKE_3 = 8'h26;
  localparam logic [7:0] MAKE_4 = 8'h25;
  localparam logic [7:0] MAKE_5 = 8'h2E;
  localparam logic [7:0] MAKE_6 = 8'h36;
  localparam logic [7:0] MAKE_7 = 8'h3D;
  localparam logic [7:0] MAKE_8 = 8'h3E;
  localparam logic [7:0] MAKE_9 = 8'h46;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_STOP,
    RX_DONE
  } rx_state_e;

  // Maps a make code to its digit value, NO_KEY for anything else.
  function automatic logic [7:0] digit_of(input logic [7:0] code);
    case (code)
      MAKE_0:  digit_of = 8'h00;
      MAKE_1:  digit_of = 8'h01;
      MAKE_2:  digit_of = 8'h02;
      MAKE_3:  digit_of = 8'h03;
      MAKE_4:  digit_of = 8'h04;
      MAKE_5:  digit_of = 8'h05;
      MAKE_6:  digit_of = 8'h06;
      MAKE_7:  digit_of = 8'h07;
      MAKE_8:  digit_of = 8'h08;
      MAKE_9:  digit_of = 8'h09;
      default: digit_of = NO_KEY;
    endcase
  endfunction

endpackage

// File: rtl/kbd_if_ps2_rx.sv
// PS/2 frame receiver: input synchronizers, PS2C glitch filter, 11-bit frame
// FSM with mid-frame timeout. Odd-parity rejection when KBD_PARITY_CHECK_EN.
module ps2_rx
  import kbd_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c_i,
  input  logic       ps2d_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]            c_sync_q, d_sync_q;
  logic [FILTER_LEN-1:0] filt_sh_q;
  logic                  filt_q;
  logic                  fall;
  logic                  d_bit;

  rx_state_e   state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        start_q, start_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        parity_ok;

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync_q  <= 2'b11;
      d_sync_q  <= 2'b11;
      filt_sh_q <= '1;
      filt_q    <= 1'b1;
    end else begin
      c_sync_q  <= {c_sync_q[0], ps2c_i};
      d_sync_q  <= {d_sync_q[0], ps2d_i};
      filt_sh_q <= {filt_sh_q[FILTER_LEN-2:0], c_sync_q[1]};
      if (&filt_sh_q)       filt_q <= 1'b1;
      else if (~|filt_sh_q) filt_q <= 1'b0;
    end
  end

  assign fall  = filt_q && (filt_sh_q == '0);
  assign d_bit = d_sync_q[1];

`ifdef KBD_PARITY_CHECK_EN
  logic par_q;
  always_ff @(posedge clk) begin
    if (reset)                                  par_q <= 1'b0;
    else if (state_q == RX_DATA && fall && cnt_q == 4'd8) par_q <= d_bit;
  end
  assign parity_ok = ^{data_q, par_q};
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RX_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      start_q <= 1'b1;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      tmo_q   <= tmo_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    tmo_d   = '0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          start_d = d_bit;
          state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (fall) begin
          if (cnt_q < 4'd8) data_d = {d_bit, data_q[7:1]};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd8) state_d = RX_STOP;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == TW'(TIMEOUT - 1)) state_d = RX_IDLE;
        end
      end
      RX_STOP: begin
        if (fall) begin
          state_d = (!start_q && d_bit && parity_ok) ? RX_DONE : RX_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == TW'(TIMEOUT - 1)) state_d = RX_IDLE;
        end
      end
      RX_DONE: state_d = RX_IDLE;
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o       = data_q;
  assign byte_valid_o = (state_q == RX_DONE);

endmodule

// File: rtl/kbd_if.sv
// PS/2 keyboard front end: decodes digits into a pending key, shifts them into
// a 4-digit buffer on request, and tracks alarm/time set modes.
module kbd_if
  import kbd_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        shift,
  input  logic        PS2C,
  input  logic        PS2D,
  output logic [31:0] key_buffer,
  output logic [7:0]  key,
  output logic        set_alarm,
  output logic        set_time
);

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  digit;

  logic [7:0]  key_q, key_d;
  logic [31:0] buf_q, buf_d;
  logic        alarm_q, alarm_d;
  logic        time_q, time_d;
  logic        brk_q, brk_d;
  logic        ext_q, ext_d;

  ps2_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .ps2c_i      (PS2C),
    .ps2d_i      (PS2D),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q   <= NO_KEY;
      buf_q   <= '0;
      alarm_q <= 1'b0;
      time_q  <= 1'b0;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
    end else begin
      key_q   <= key_d;
      buf_q   <= buf_d;
      alarm_q <= alarm_d;
      time_q  <= time_d;
      brk_q   <= brk_d;
      ext_q   <= ext_d;
    end
  end

  always_comb begin
    key_d   = key_q;
    buf_d   = buf_q;
    alarm_d = alarm_q;
    time_d  = time_q;
    brk_d   = brk_q;
    ext_d   = ext_q;
    digit   = digit_of(rx_byte);

    if (shift && key_q != NO_KEY) begin
      buf_d = {buf_q[23:0], key_q};
      key_d = NO_KEY;
    end

    // A digit decoded on the same edge as a shift overrides the clear above.
    if (rx_valid) begin
      if (brk_q || ext_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (rx_byte == BREAK) begin
        brk_d = 1'b1;
      end else if (rx_byte == EXT) begin
        ext_d = 1'b1;
      end else if (digit != NO_KEY) begin
        key_d = digit;
      end else begin
        case (rx_byte)
          KEY_A: begin
            alarm_d = 1'b1;
            time_d  = 1'b0;
          end
          KEY_T: begin
            alarm_d = 1'b0;
            time_d  = 1'b1;
          end
          KEY_ENTER, KEY_ESC: begin
            alarm_d = 1'b0;
            time_d  = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign key        = key_q;
  assign key_buffer = buf_q;
  assign set_alarm  = alarm_q;
  assign set_time   = time_q;

endmodule

// File: tb/tb_kbd_if.sv
// Self-checking bench for kbd_if: table of scan-code frames plus directed
// sequences for shift collision, parity, timeout and mid-frame reset.
`timescale 1ns/1ps
module tb_kbd_if;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 300;
  localparam int HALF       = 20;

  logic        clk = 1'b0;
  logic        reset, shift, ps2c, ps2d;
  logic [31:0] key_buffer;
  logic [7:0]  key;
  logic        set_alarm, set_time;

  always #5 clk = ~clk;

  kbd_if #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .shift     (shift),
    .PS2C      (ps2c),
    .PS2D      (ps2d),
    .key_buffer(key_buffer),
    .key       (key),
    .set_alarm (set_alarm),
    .set_time  (set_time)
  );

  typedef struct {
    logic [7:0]  code;
    logic        do_shift;
    logic [7:0]  exp_key;
    logic [31:0] exp_buf;
    logic        exp_alarm;
    logic        exp_time;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [7:0] k, input logic [31:0] b,
                           input logic a, input logic t);
    check({name, "_key"}, {24'h0, key}, {24'h0, k});
    check({name, "_buf"}, key_buffer, b);
    check({name, "_alarm"}, {31'h0, set_alarm}, {31'h0, a});
    check({name, "_time"}, {31'h0, set_time}, {31'h0, t});
    check({name, "_excl"}, {31'h0, set_alarm & set_time}, 32'h0);
  endtask

  task automatic send_bit(input logic b);
    ps2d = b;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit(~(^code) ^ bad_par);
    send_bit(1'b1);
    ps2d = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic pulse_shift();
    @(negedge clk) shift = 1'b1;
    @(negedge clk) shift = 1'b0;
  endtask

  logic [31:0] prev_buf;
  logic [7:0]  exp_par_key;
  bit          seen;

  initial begin
    vecs.push_back('{8'h16, 1'b1, 8'h01, 32'h0000_0101, 1'b0, 1'b0});
    vecs.push_back('{8'h1E, 1'b1, 8'h02, 32'h0001_0102, 1'b0, 1'b0});
    vecs.push_back('{8'h26, 1'b1, 8'h03, 32'h0101_0203, 1'b0, 1'b0});
    vecs.push_back('{8'h25, 1'b1, 8'h04, 32'h0102_0304, 1'b0, 1'b0});
    vecs.push_back('{8'h2E, 1'b1, 8'h05, 32'h0203_0405, 1'b0, 1'b0});
    vecs.push_back('{8'hF0, 1'b0, 8'hFF, 32'h0203_0405, 1'b0, 1'b0});
    vecs.push_back('{8'h16, 1'b0, 8'hFF, 32'h0203_0405, 1'b0, 1'b0});
    vecs.push_back('{8'h1C, 1'b0, 8'hFF, 32'h0203_0405, 1'b1, 1'b0});
    vecs.push_back('{8'h2C, 1'b0, 8'hFF, 32'h0203_0405, 1'b0, 1'b1});
    vecs.push_back('{8'h5A, 1'b0, 8'hFF, 32'h0203_0405, 1'b0, 1'b0});
    vecs.push_back('{8'hE0, 1'b0, 8'hFF, 32'h0203_0405, 1'b0, 1'b0});
    vecs.push_back('{8'h45, 1'b0, 8'hFF, 32'h0203_0405, 1'b0, 1'b0});
    vecs.push_back('{8'h1C, 1'b0, 8'hFF, 32'h0203_0405, 1'b1, 1'b0});
    vecs.push_back('{8'h76, 1'b0, 8'hFF, 32'h0203_0405, 1'b0, 1'b0});
    vecs.push_back('{8'h45, 1'b0, 8'h00, 32'h0203_0405, 1'b0, 1'b0});
    vecs.push_back('{8'h46, 1'b1, 8'h09, 32'h0304_0509, 1'b0, 1'b0});
    vecs.push_back('{8'h3D, 1'b0, 8'h07, 32'h0304_0509, 1'b0, 1'b0});
    vecs.push_back('{8'h1A, 1'b0, 8'h07, 32'h0304_0509, 1'b0, 1'b0});
    vecs.push_back('{8'h2C, 1'b1, 8'h07, 32'h0405_0907, 1'b0, 1'b1});
    vecs.push_back('{8'h76, 1'b0, 8'hFF, 32'h0405_0907, 1'b0, 1'b0});

    // Reset with both PS/2 lines held low.
    reset = 1'b1;
    shift = 1'b0;
    ps2c  = 1'b0;
    ps2d  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_all("reset", 8'hFF, 32'h0, 1'b0, 1'b0);
    #2000;
    @(negedge clk);
    check_all("lines_low", 8'hFF, 32'h0, 1'b0, 1'b0);
    ps2c = 1'b1;
    ps2d = 1'b1;
    repeat (TIMEOUT + 50) @(negedge clk);

    // First digit and shift handshake.
    send_frame(8'h16, 1'b0);
    check_all("first_digit", 8'h01, 32'h0, 1'b0, 1'b0);
    pulse_shift();
    check_all("first_shift", 8'hFF, 32'h0000_0001, 1'b0, 1'b0);

    prev_buf = 32'h0000_0001;
    foreach (vecs[i]) begin
      send_frame(vecs[i].code, 1'b0);
      check_all($sformatf("vec%0d_pre", i), vecs[i].exp_key, prev_buf,
                vecs[i].exp_alarm, vecs[i].exp_time);
      if (vecs[i].do_shift) begin
        pulse_shift();
        check_all($sformatf("vec%0d_post", i), 8'hFF, vecs[i].exp_buf,
                  vecs[i].exp_alarm, vecs[i].exp_time);
      end
      prev_buf = vecs[i].exp_buf;
    end

    // Shift with no key pending does nothing.
    pulse_shift();
    check_all("empty_shift", 8'hFF, 32'h0405_0907, 1'b0, 1'b0);

    // Shift and a new digit on the same edge: old key shifted, new key loaded.
    send_frame(8'h3E, 1'b0);
    check_all("pend8", 8'h08, 32'h0405_0907, 1'b0, 1'b0);
    seen = 1'b0;
    fork
      send_frame(8'h36, 1'b0);
      begin
        for (int c = 0; c < 2000 && !seen; c++) begin
          @(negedge clk);
          if (u_dut.rx_valid) seen = 1'b1;
        end
        if (seen) begin
          shift = 1'b1;
          @(negedge clk) shift = 1'b0;
        end
      end
    join
    check("collide_seen", {31'h0, seen}, 32'h1);
    check_all("collide", 8'h06, 32'h0509_0708, 1'b0, 1'b0);
    pulse_shift();
    check_all("collide_shift", 8'hFF, 32'h0907_0806, 1'b0, 1'b0);

    // Digit '0' with a wrong parity bit.
`ifdef KBD_PARITY_CHECK_EN
    exp_par_key = 8'hFF;
`else
    exp_par_key = 8'h00;
`endif
    send_frame(8'h45, 1'b1);
    check_all("bad_parity", exp_par_key, 32'h0907_0806, 1'b0, 1'b0);

    // Abandoned partial frame, then a clean frame after the timeout.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    ps2d = 1'b1;
    repeat (TIMEOUT + 50) @(negedge clk);
    send_frame(8'h2E, 1'b0);
    check_all("after_timeout", 8'h05, 32'h0907_0806, 1'b0, 1'b0);

    // Reset in the middle of a frame.
    send_frame(8'h1C, 1'b0);
    check_all("pre_reset", 8'h05, 32'h0907_0806, 1'b1, 1'b0);
    for (int b = 0; b < 5; b++) send_bit(1'b0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check_all("mid_reset", 8'hFF, 32'h0, 1'b0, 1'b0);
    send_frame(8'h26, 1'b0);
    check_all("post_reset", 8'h03, 32'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
